// File: rtl/ps_pkg.sv
// Shared types and helpers for the PacketStream store-and-forward FIFO.
package ps_pkg;

  typedef enum logic {
    PS_NORMAL = 1'b0,
    PS_FORCE  = 1'b1
  } ps_state_t;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ps_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ps_sdp_ram.sv
// Simple dual-port RAM with registered read; array is not reset.
module ps_sdp_ram #(
  parameter int unsigned DWIDTH  = 9,
  parameter int unsigned DEPTH   = 16,
  parameter              RAMTYPE = "MLAB",
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  (* ramstyle = RAMTYPE *) logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ps_pkt_fifo.sv
// Store-and-forward PacketStream FIFO with cut-through fallback for oversize packets.
// Optional occupancy/packet counters are enabled by defining PS_PKT_FIFO_STATUS_EN.
module ps_pkt_fifo
  import ps_pkg::*;
#(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter              RAMTYPE = "MLAB"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic              i_val,
  input  logic              i_eop,
  output logic              i_rdy,
  output logic [DWIDTH-1:0] o_dat,
  output logic              o_val,
  output logic              o_eop,
  input  logic              o_rdy
`ifdef PS_PKT_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH+1):0] o_used,
  output logic [$clog2(DEPTH+1):0] o_pkts
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ps_ptr_w(DEPTH);
  localparam int unsigned MW = DWIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  ps_state_t     state_q, state_d;
  logic          full_c, wr_en_c, load_c, o_val_d;
  logic [MW-1:0] ram_rdata, head_c, byp_q;
  logic          byp_sel_q;

  ps_sdp_ram #(
    .DWIDTH  (MW),
    .DEPTH   (DEPTH),
    .RAMTYPE (RAMTYPE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({i_eop, i_dat}),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Datapath control; the read address runs one step ahead so the RAM head is ready each cycle.
  always_comb begin
    full_c   = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    i_rdy    = ~full_c;
    wr_en_c  = i_val & ~full_c;
    load_c   = (rd_ptr_q != cm_ptr_q) && (!o_val || o_rdy);
    wr_ptr_d = wr_ptr_q + PW'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PW'(load_c);
    head_c   = byp_sel_q ? byp_q : ram_rdata;
    o_val_d  = load_c | (o_val & ~o_rdy);
  end

  // Commit boundary and normal/cut-through state.
  always_comb begin
    state_d  = state_q;
    cm_ptr_d = cm_ptr_q;
    case (state_q)
      PS_NORMAL: begin
        if (wr_en_c && i_eop) cm_ptr_d = wr_ptr_d;
        if (full_c && (cm_ptr_q == rd_ptr_q)) state_d = PS_FORCE;
      end
      PS_FORCE: begin
        cm_ptr_d = wr_ptr_d;
        if (wr_en_c && i_eop) state_d = PS_NORMAL;
      end
    endcase
  end

  // Bypass covers a word written on the same edge the RAM read its address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      state_q   <= PS_NORMAL;
      byp_q     <= '0;
      byp_sel_q <= 1'b0;
      o_dat     <= '0;
      o_eop     <= 1'b0;
      o_val     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      state_q   <= state_d;
      byp_q     <= {i_eop, i_dat};
      byp_sel_q <= wr_en_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
      o_val     <= o_val_d;
      if (load_c) begin
        o_dat <= head_c[DWIDTH-1:0];
        o_eop <= head_c[DWIDTH];
      end
    end
  end

`ifdef PS_PKT_FIFO_STATUS_EN
  localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

  logic [CW-1:0] used_d, pkts_d;

  always_comb begin
    used_d = CW'(wr_ptr_d - rd_ptr_d) + CW'(o_val_d);
    pkts_d = o_pkts + CW'(wr_en_c & i_eop) - CW'(o_val & o_rdy & o_eop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_used <= '0;
      o_pkts <= '0;
    end else begin
      o_used <= used_d;
      o_pkts <= pkts_d;
    end
  end
`endif

endmodule
